// File: rtl/monitor_eval_scheduler_pkg.sv
// Shared definitions for the monitor evaluation scheduler.
//   DATA_W_DEF / TIME_W_DEF / N_PER_DEF : default payload, timestamp and
//                                         periodic-stream counts
//   MASK_IN / MASK_PER_BASE             : bit positions inside a slot mask
//   slot_rec_t                          : one evaluation slot {mask, data, time}
package monitor_eval_scheduler_pkg;

  localparam int DATA_W_DEF    = 64;
  localparam int TIME_W_DEF    = 32;
  localparam int N_PER_DEF     = 2;

  localparam int MASK_IN       = 0;
  localparam int MASK_PER_BASE = 1;

  typedef struct packed {
    logic [N_PER_DEF:0]            mask;
    logic signed [DATA_W_DEF-1:0]  data;
    logic [TIME_W_DEF-1:0]         ts;
  } slot_rec_t;

endpackage

// File: rtl/monitor_eval_scheduler_event_fifo.sv
// Synchronous FIFO buffering timestamped input events.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write wdata_i (honoured when not full, or when a pop
//                  frees a slot in the same cycle)
//   pop_i        : drop the head entry (ignored when empty)
//   rdata_o      : head entry, valid while !empty_o
//   full_o       : registered full flag
//   empty_o      : registered empty flag
//   level_o      : occupancy
module event_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && !empty_q;
    do_push = push_i && (!full_q || do_pop);
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  // Flags come from the next level so they are registered yet exact.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == (AW+1)'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/monitor_eval_scheduler.sv
// Evaluation scheduler for the stream-monitor datapath.
// Buffers timestamped input events, generates periodic pacing ticks and
// issues one evaluation slot at a time to the evaluator.
//   clk, rst              : clock, synchronous active-high reset
//   en                    : global enable, all state holds while low
//   in_valid/in_data      : input event offer (accepted with in_ready)
//   in_ready              : event buffer not full (registered flag)
//   slot_valid/slot_ready : slot handshake toward the evaluator
//   slot_mask             : bit0 input stream, bit k+1 periodic stream k
//   slot_data/slot_time   : payload (0 if no input) and slot timestamp
//   miss_flag/miss_count  : sticky lost-tick flag, saturating count
//   fifo_level            : event buffer occupancy
module monitor_eval_scheduler
  import monitor_eval_scheduler_pkg::*;
#(
  parameter int                      DATA_W     = DATA_W_DEF,
  parameter int                      TIME_W     = TIME_W_DEF,
  parameter int                      N_PER      = N_PER_DEF,
  parameter logic [N_PER*TIME_W-1:0] PERIODS    = {32'd1000, 32'd500},
  parameter int                      FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           in_valid,
  input  logic signed [DATA_W-1:0]       in_data,
  output logic                           in_ready,
  output logic                           slot_valid,
  input  logic                           slot_ready,
  output logic [N_PER:0]                 slot_mask,
  output logic signed [DATA_W-1:0]       slot_data,
  output logic [TIME_W-1:0]              slot_time,
  output logic                           miss_flag,
  output logic [7:0]                     miss_count,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

  typedef struct packed {
    logic signed [DATA_W-1:0] data;
    logic [TIME_W-1:0]        ts;
  } ev_t;

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  function automatic logic [TIME_W-1:0] period_of(input int k);
    return PERIODS[k*TIME_W +: TIME_W];
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input int b);
    logic [8:0] s;
    if (b >= 255) return 8'hFF;
    s = {1'b0, a} + 9'(b);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [TIME_W-1:0]       time_q;
  logic [TIME_W-1:0]       pcnt_q [N_PER];
  logic [N_PER-1:0]        pend_q, pend_d, tick, lost;
  logic                    miss_flag_q;
  logic [7:0]              miss_cnt_q, miss_cnt_d;
  state_t                  state_q;
  logic                    slot_valid_q;
  logic [N_PER:0]          slot_mask_q, mask_d;
  logic signed [DATA_W-1:0] slot_data_q;
  logic [TIME_W-1:0]       slot_time_q;

  ev_t                     head, wr_ev;
  logic [$bits(ev_t)-1:0]  fifo_rdata;
  logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                    hs, load;

  assign in_ready  = !rst && !fifo_full;
  assign fifo_push = en && in_valid && in_ready;
  assign wr_ev     = '{data: in_data, ts: time_q};

  event_fifo #(
    .WIDTH ($bits(ev_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (wr_ev),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    head = ev_t'(fifo_rdata);
    hs   = en && (state_q == S_OFFER) && slot_ready;
    // A slot is (re)loaded from IDLE or in the cycle the current one is taken.
    load = en && (!fifo_empty || (pend_q != '0)) && ((state_q == S_IDLE) || hs);
    fifo_pop = load && !fifo_empty;
    for (int k = 0; k < N_PER; k++) begin
      tick[k] = en && (pcnt_q[k] == period_of(k) - TIME_W'(1));
    end
    // A load captures every pending bit, so a tick then only re-arms.
    lost       = tick & pend_q & ~{N_PER{load}};
    pend_d     = (load ? '0 : pend_q) | tick;
    miss_cnt_d = sat_add8(miss_cnt_q, $countones(lost));
    mask_d                          = '0;
    mask_d[MASK_IN]                 = !fifo_empty;
    mask_d[MASK_PER_BASE +: N_PER]  = pend_q;
  end

  // Time base, pacing counters and lost-tick accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      time_q      <= '0;
      for (int k = 0; k < N_PER; k++) pcnt_q[k] <= '0;
      pend_q      <= '0;
      miss_flag_q <= 1'b0;
      miss_cnt_q  <= '0;
    end else if (en) begin
      time_q <= time_q + TIME_W'(1);
      for (int k = 0; k < N_PER; k++) begin
        pcnt_q[k] <= tick[k] ? '0 : pcnt_q[k] + TIME_W'(1);
      end
      pend_q <= pend_d;
      if (lost != '0) begin
        miss_flag_q <= 1'b1;
        miss_cnt_q  <= miss_cnt_d;
      end
    end
  end

  // Slot register and offer state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      slot_valid_q <= 1'b0;
      slot_mask_q  <= '0;
      slot_data_q  <= '0;
      slot_time_q  <= '0;
    end else if (load) begin
      state_q      <= S_OFFER;
      slot_valid_q <= 1'b1;
      slot_mask_q  <= mask_d;
      slot_data_q  <= fifo_empty ? '0 : head.data;
      slot_time_q  <= fifo_empty ? time_q : head.ts;
    end else if (hs) begin
      state_q      <= S_IDLE;
      slot_valid_q <= 1'b0;
    end
  end

  assign slot_valid = slot_valid_q;
  assign slot_mask  = slot_mask_q;
  assign slot_data  = slot_data_q;
  assign slot_time  = slot_time_q;
  assign miss_flag  = miss_flag_q;
  assign miss_count = miss_cnt_q;

endmodule
